// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the single-port SRAM controller slice.
package sram_ctrl_pkg;

  // Controller operating state: zero-fill after reset, then serve requesters.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int unsigned NUM_REQ = 2;

  // Requester identifiers; also used as grant-vector indices and owner tags.
  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

endpackage : sram_ctrl_pkg

// File: rtl/rr_arb2.sv
// Two-way round-robin selector; the pointer moves only when a grant is issued.
module rr_arb2
  import sram_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt
);

  // 1 = requester B wins a tie, 0 = requester A wins a tie.
  logic prio_b_q;

  // Grant selection; a tie goes to whoever was not granted most recently.
  always_comb begin
    gnt = '0;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = prio_b_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Priority pointer: after granting A, favour B next, and vice versa.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_b_q <= 1'b0;
    end else if (|gnt) begin
      prio_b_q <= gnt[ID_A];
    end
  end

endmodule : rr_arb2

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM read/write port between two requesters, with optional
// zero-fill of the whole array after reset.
module sram_port_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_WMASKS     = 4,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [NUM_WMASKS-1:0] a_wmask,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [NUM_WMASKS-1:0] b_wmask,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  a_gnt,
  output logic                  b_gnt,
  output logic                  a_rvalid,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  init_done,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  init_done_q;
  logic                  rd_pend_q;
  logic                  rd_owner_q;
  logic                  arb_en;
  logic [NUM_REQ-1:0]    arb_req;
  logic [NUM_REQ-1:0]    arb_gnt;
  logic                  rd_issue;

  // Requesters only compete once the clear sweep is over and reset is low.
  assign arb_en  = (state_q == ST_RUN) && !rst;
  assign arb_req = {b_req, a_req};

  rr_arb2 u_rr_arb2 (
    .clk (clk),
    .rst (rst),
    .en  (arb_en),
    .req (arb_req),
    .gnt (arb_gnt)
  );

  // Next-state logic: walk the clear counter and leave CLEAR after the last word.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        if (clr_cnt_q == '1) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // State register, clear counter and the registered ready flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= (state_d == ST_RUN);
    end
  end

  // SRAM command mux: clear writes, else the granted requester, else idle.
  always_comb begin
    sram_csb0   = 1'b1;
    sram_web0   = 1'b1;
    sram_wmask0 = '0;
    sram_addr0  = '0;
    sram_din0   = '0;
    if (!rst) begin
      if (state_q == ST_CLEAR) begin
        sram_csb0   = 1'b0;
        sram_web0   = 1'b0;
        sram_wmask0 = '1;
        sram_addr0  = clr_cnt_q;
        sram_din0   = '0;
      end else if (arb_gnt[ID_A]) begin
        sram_csb0   = 1'b0;
        sram_web0   = ~a_we;
        sram_wmask0 = a_wmask;
        sram_addr0  = a_addr;
        sram_din0   = a_wdata;
      end else if (arb_gnt[ID_B]) begin
        sram_csb0   = 1'b0;
        sram_web0   = ~b_we;
        sram_wmask0 = b_wmask;
        sram_addr0  = b_addr;
        sram_din0   = b_wdata;
      end
    end
  end

  assign rd_issue = (arb_gnt[ID_A] && !a_we) || (arb_gnt[ID_B] && !b_we);

  // One-deep read tracker: remembers whether a read is returning and to whom.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= ID_A;
    end else begin
      rd_pend_q  <= rd_issue;
      rd_owner_q <= arb_gnt[ID_B];
    end
  end

  // Handshake outputs; reset suppresses anything already in flight.
  assign a_gnt     = arb_gnt[ID_A];
  assign b_gnt     = arb_gnt[ID_B];
  assign a_rvalid  = rd_pend_q && (rd_owner_q == ID_A) && !rst;
  assign b_rvalid  = rd_pend_q && (rd_owner_q == ID_B) && !rst;
  assign init_done = init_done_q && !rst;
  assign a_rdata   = sram_dout0;
  assign b_rdata   = sram_dout0;

endmodule : sram_port_arbiter

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, SRAM word-address width (256 words).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, SRAM word width.
REQ-003 SHALL have parameter NUM_WMASKS, default 4, byte-lane write-mask width.
REQ-004 SHALL have parameter CLEAR_ON_RESET, default 1, zero-fill the SRAM after reset when 1.
REQ-005 SHALL have one clock and one reset: clk, rst; reset is synchronous and active-high.
REQ-006 Ports, in order (name  direction  width  meaning):
- clk  in  1  clock, also drives SRAM clk0
- rst  in  1  synchronous active-high reset
- a_req / b_req  in  1  requester A / B command valid
- a_we / b_we  in  1  1 = write, 0 = read
- a_wmask / b_wmask  in  NUM_WMASKS  byte enables, write only
- a_addr / b_addr  in  ADDR_WIDTH  word address
- a_wdata / b_wdata  in  DATA_WIDTH  write data
- a_gnt / b_gnt  out  1  command accepted this cycle
- a_rvalid / b_rvalid  out  1  read data valid
- a_rdata / b_rdata  out  DATA_WIDTH  read data
- init_done  out  1  clear sequence finished, commands accepted
- sram_csb0  out  1  active-low chip select to SRAM port 0
- sram_web0  out  1  active-low write enable
- sram_wmask0  out  NUM_WMASKS  write mask
- sram_addr0  out  ADDR_WIDTH  address
- sram_din0  out  DATA_WIDTH  write data
- sram_dout0  in  DATA_WIDTH  SRAM read data

Function
REQ-007 FSM states SHALL be CLEAR and RUN; reset enters CLEAR if CLEAR_ON_RESET=1, else RUN.
REQ-008 In CLEAR, the block SHALL issue one write per cycle: csb0=0, web0=0, wmask0 all ones, din0=0, addr0 = clear counter 0..2^ADDR_WIDTH-1; it enters RUN the cycle after address 2^ADDR_WIDTH-1 is issued.
REQ-009 In CLEAR, gnt SHALL be 0 for both requesters regardless of req.
REQ-010 init_done SHALL be 1 exactly when state is RUN, registered.
REQ-011 In RUN, the SRAM command SHALL be driven combinationally from the winning requester in the same cycle its gnt=1; no request means csb0=1.
REQ-012 Arbitration SHALL be round-robin: with both req=1, the requester not granted most recently wins; the pointer updates only on a grant; after reset, A has priority.
REQ-013 gnt SHALL be single-cycle per accepted command; a held req SHALL receive a new command grant each cycle it wins.
REQ-014 A read granted in cycle N SHALL assert that requester's rvalid in cycle N+1 only, with rdata = sram_dout0 (SRAM captures on posedge and updates dout0 on the following negedge).
REQ-015 rdata for a requester without rvalid SHALL be don't-care to consumers; a_rdata and b_rdata SHALL both drive sram_dout0.
REQ-016 Writes SHALL produce no rvalid; wmask0 SHALL pass through unmodified; a write with wmask all zero SHALL still be granted.
REQ-017 Back-to-back reads from alternating requesters SHALL sustain one command per cycle with each rvalid routed to its own requester (one-bit registered owner tag).
REQ-018 A read and write to the same address in consecutive cycles SHALL be ordered by grant order.

Reset
REQ-019 While rst=1: gnt=0, rvalid=0, init_done=0, sram_csb0=1, sram_web0=1, clear counter=0, RR pointer to favour A.
REQ-020 rst asserted mid-CLEAR or with a read in flight SHALL drop the pending rvalid and restart CLEAR at address 0.

Structure
REQ-021 State enum (CLEAR/RUN) and requester-id constants SHALL live in shared package sram_ctrl_pkg.
REQ-022 The round-robin selector SHALL be a sub-module rr_arb2 (two requests, grant vector, pointer update on grant).

Verification
REQ-023 Reset with CLEAR_ON_RESET=1 -> 256 consecutive zero writes to addresses 0..255, then init_done=1 in cycle 257; requests during CLEAR never granted.
REQ-024 A writes 0xDEADBEEF to addr 0x10 with wmask 0xF, then reads it -> a_rvalid one cycle after read grant, a_rdata=0xDEADBEEF.
REQ-025 Write 0x11223344 with wmask 0x5 onto a cleared word, read back -> 0x00220044.
REQ-026 a_req and b_req held high for 6 cycles, both reads -> grants alternate A,B,A,B,A,B; each rvalid appears on the matching requester only.
REQ-027 rst pulsed at CLEAR address 100 -> counter restarts at 0; full 256-write clear completes before init_done.
REQ-028 rst asserted the cycle after a B read grant -> b_rvalid stays 0.
